// File: rtl/sky130_sram_1rw_tiny_ctrl_if.sv
// Host-side request/response channel of the sky130_sram_1rw_tiny controller.
// The master drives requests and consumes responses; the controller is the slave.
interface sky130_sram_1rw_tiny_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned NUM_WMASKS = 4
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [NUM_WMASKS-1:0] req_wmask;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sky130_sram_1rw_tiny_ctrl.sv
// Request/response initiator for one 16x32 sky130_sram_1rw_tiny macro.
// Define SRAM_CTRL_CLEAR_EN to zero the whole array after every reset.
module sky130_sram_1rw_tiny_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned NUM_WMASKS = 4
) (
   input  logic                  clk0,
   input  logic                  rst0,
   sky130_sram_1rw_tiny_ctrl_if.slave host,
   output logic                  init_busy,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_DATA,
`ifdef SRAM_CTRL_CLEAR_EN
      ST_RSP,
      ST_INIT
`else
      ST_RSP
`endif
   } state_t;

`ifdef SRAM_CTRL_CLEAR_EN
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'((1 << ADDR_WIDTH) - 1);
   localparam state_t RST_STATE = ST_INIT;
   localparam logic   RST_BUSY  = 1'b1;
   logic [ADDR_WIDTH-1:0] init_addr;
`else
   localparam state_t RST_STATE = ST_IDLE;
   localparam logic   RST_BUSY  = 1'b0;
`endif

   state_t state;

   // Single-process FSM; req_ready is a registered copy of (state == ST_IDLE).
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         state          <= RST_STATE;
         host.req_ready <= ~RST_BUSY;
         host.rsp_valid <= 1'b0;
         host.rsp_rdata <= '0;
         init_busy      <= RST_BUSY;
         sram_csb0      <= 1'b1;
         sram_web0      <= 1'b1;
         sram_wmask0    <= '0;
         sram_addr0     <= '0;
         sram_din0      <= '0;
`ifdef SRAM_CTRL_CLEAR_EN
         init_addr      <= '0;
`endif
      end else begin
         // Chip select is a one-cycle pulse; the other pins keep their last value.
         sram_csb0 <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (host.req_valid) begin
                  if (host.req_we) begin
                     if (|host.req_wmask) begin
                        sram_csb0   <= 1'b0;
                        sram_web0   <= 1'b0;
                        sram_addr0  <= host.req_addr;
                        sram_wmask0 <= host.req_wmask;
                        sram_din0   <= host.req_wdata;
                     end
                  end else begin
                     sram_csb0      <= 1'b0;
                     sram_web0      <= 1'b1;
                     sram_addr0     <= host.req_addr;
                     state          <= ST_RD_ISSUE;
                     host.req_ready <= 1'b0;
                  end
               end
            end
            ST_RD_ISSUE: state <= ST_RD_DATA;
            ST_RD_DATA: begin
               // dout0 is only valid up to this edge.
               host.rsp_rdata <= sram_dout0;
               host.rsp_valid <= 1'b1;
               state          <= ST_RSP;
            end
            ST_RSP: begin
               if (host.rsp_ready) begin
                  host.rsp_valid <= 1'b0;
                  host.req_ready <= 1'b1;
                  state          <= ST_IDLE;
               end
            end
`ifdef SRAM_CTRL_CLEAR_EN
            ST_INIT: begin
               sram_csb0   <= 1'b0;
               sram_web0   <= 1'b0;
               sram_wmask0 <= '1;
               sram_din0   <= '0;
               sram_addr0  <= init_addr;
               init_addr   <= init_addr + ADDR_WIDTH'(1);
               if (init_addr == ADDR_MAX) begin
                  state          <= ST_IDLE;
                  init_busy      <= 1'b0;
                  host.req_ready <= 1'b1;
               end
            end
`endif
            default: begin
               state          <= ST_IDLE;
               host.req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sky130_sram_1rw_tiny_ctrl.sv
// Bench for sky130_sram_1rw_tiny_ctrl with a behavioural macro and a memory reference model.
// Build with SRAM_CTRL_CLEAR_EN defined to cover the clear engine.
`timescale 1ns/1ps
module tb_sky130_sram_1rw_tiny_ctrl;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 4;
   localparam int unsigned MW = 4;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clk0 = 1'b0;
   logic          rst0 = 1'b1;
   logic          init_busy;
   logic          sram_csb0, sram_web0;
   logic [MW-1:0] sram_wmask0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0;
   logic [DW-1:0] sram_dout0;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] ref_mem [DEPTH];

   sky130_sram_1rw_tiny_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(MW)) host_if ();

   sky130_sram_1rw_tiny_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(MW)) dut (
      .clk0        (clk0),
      .rst0        (rst0),
      .host        (host_if),
      .init_busy   (init_busy),
      .sram_csb0   (sram_csb0),
      .sram_web0   (sram_web0),
      .sram_wmask0 (sram_wmask0),
      .sram_addr0  (sram_addr0),
      .sram_din0   (sram_din0),
      .sram_dout0  (sram_dout0)
   );

   always #5 clk0 = ~clk0;

   // Behavioural macro: pins sampled at posedge, write commits and read data appear at
   // the following negedge, and dout0 goes unknown right after the next posedge.
   logic [DW-1:0] mac_mem [DEPTH];
   logic          mac_en, mac_we;
   logic [AW-1:0] mac_addr;
   logic [MW-1:0] mac_mask;
   logic [DW-1:0] mac_din;
   initial mac_en = 1'b0;

   always @(posedge clk0) begin
      mac_en     <= ~sram_csb0;
      mac_we     <= ~sram_web0;
      mac_addr   <= sram_addr0;
      mac_mask   <= sram_wmask0;
      mac_din    <= sram_din0;
      sram_dout0 <= 'x;
   end

   always @(negedge clk0) begin
      if (mac_en) begin
         if (mac_we) begin
            for (int b = 0; b < int'(MW); b++)
               if (mac_mask[b]) mac_mem[mac_addr][8*b +: 8] <= mac_din[8*b +: 8];
         end else begin
            sram_dout0 <= mac_mem[mac_addr];
         end
      end
   end

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                           input logic [MW-1:0] mask);
      logic [DW-1:0] r;
      r = old_v;
      for (int b = 0; b < int'(MW); b++)
         if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

   task automatic step();
      @(posedge clk0);
      #1;
   endtask

   task automatic wait_ready(input string who);
      int n;
      n = 0;
      while (host_if.req_ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      checks++;
      if (host_if.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout: req_ready=%b after %0d cycles, need 1", who, host_if.req_ready, n);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
      wait_ready("write");
      host_if.req_valid = 1'b1;
      host_if.req_we    = 1'b1;
      host_if.req_addr  = a;
      host_if.req_wmask = m;
      host_if.req_wdata = d;
      step();
      host_if.req_valid = 1'b0;
      checks++;
      if (m != '0) begin
         if ({sram_csb0, sram_web0, sram_addr0, sram_wmask0, sram_din0} !== {1'b0, 1'b0, a, m, d}) begin
            errors++;
            $display("FAIL write_pins: csb=%b web=%b addr=%h mask=%h din=%h, need 0 0 %h %h %h",
                     sram_csb0, sram_web0, sram_addr0, sram_wmask0, sram_din0, a, m, d);
         end
      end else if (sram_csb0 !== 1'b1) begin
         errors++;
         $display("FAIL write_mask0_csb: csb=%b, need 1", sram_csb0);
      end
      checks++;
      if (host_if.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL write_ready: req_ready=%b, need 1", host_if.req_ready);
      end
      ref_mem[a] = merge(ref_mem[a], d, m);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int hold);
      logic [DW-1:0] exp_d;
      exp_d = ref_mem[a];
      wait_ready("read");
      host_if.req_valid = 1'b1;
      host_if.req_we    = 1'b0;
      host_if.req_addr  = a;
      host_if.rsp_ready = 1'b0;
      step();
      host_if.req_valid = 1'b0;
      checks++;
      if ({sram_csb0, sram_web0, sram_addr0, host_if.req_ready, host_if.rsp_valid} !== {1'b0, 1'b1, a, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL read_issue: csb=%b web=%b addr=%h ready=%b rsp_valid=%b, need 0 1 %h 0 0",
                  sram_csb0, sram_web0, sram_addr0, host_if.req_ready, host_if.rsp_valid, a);
      end
      step();
      checks++;
      if ({sram_csb0, host_if.rsp_valid, host_if.req_ready} !== 3'b100) begin
         errors++;
         $display("FAIL read_wait: csb=%b rsp_valid=%b ready=%b, need 1 0 0",
                  sram_csb0, host_if.rsp_valid, host_if.req_ready);
      end
      step();
      checks++;
      if (host_if.rsp_valid !== 1'b1 || host_if.rsp_rdata !== exp_d) begin
         errors++;
         $display("FAIL read_data addr %h: rsp_valid=%b rdata=%h, need 1 %h", a, host_if.rsp_valid, host_if.rsp_rdata, exp_d);
      end
      for (int i = 0; i < hold; i++) begin
         step();
         checks++;
         if (host_if.rsp_valid !== 1'b1 || host_if.rsp_rdata !== exp_d || host_if.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_hold cycle %0d: rsp_valid=%b rdata=%h ready=%b, need 1 %h 0",
                     i, host_if.rsp_valid, host_if.rsp_rdata, host_if.req_ready, exp_d);
         end
      end
      host_if.rsp_ready = 1'b1;
      step();
      host_if.rsp_ready = 1'b0;
      checks++;
      if (host_if.rsp_valid !== 1'b0 || host_if.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL read_consume: rsp_valid=%b ready=%b, need 0 1", host_if.rsp_valid, host_if.req_ready);
      end
   endtask

   task automatic apply_reset();
      rst0 = 1'b1;
      step();
      step();
      rst0 = 1'b0;
   endtask

   task automatic test_reset();
      logic exp_busy;
`ifdef SRAM_CTRL_CLEAR_EN
      exp_busy = 1'b1;
`else
      exp_busy = 1'b0;
`endif
      rst0 = 1'b1;
      step();
      checks++;
      if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0} !== {1'b1, 1'b1, {MW{1'b0}}, {AW{1'b0}}, {DW{1'b0}}}) begin
         errors++;
         $display("FAIL reset_pins: csb=%b web=%b mask=%h addr=%h din=%h, need 1 1 0 0 0",
                  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0);
      end
      checks++;
      if ({host_if.rsp_valid, host_if.rsp_rdata, init_busy, host_if.req_ready} !== {1'b0, {DW{1'b0}}, exp_busy, ~exp_busy}) begin
         errors++;
         $display("FAIL reset_status: rsp_valid=%b rdata=%h busy=%b ready=%b, need 0 0 %b %b",
                  host_if.rsp_valid, host_if.rsp_rdata, init_busy, host_if.req_ready, exp_busy, ~exp_busy);
      end
      rst0 = 1'b0;
   endtask

`ifdef SRAM_CTRL_CLEAR_EN
   task automatic test_init();
      int n;
      n = 0;
      while (init_busy === 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n != int'(DEPTH)) begin
         errors++;
         $display("FAIL init_cycles: busy for %0d cycles, need %0d", n, DEPTH);
      end
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
      for (int i = 0; i < int'(DEPTH); i++) do_read(AW'(i), 0);
   endtask
`endif

   task automatic test_write_read();
      do_write(4'd3, 4'hF, 32'hDEADBEEF);
      do_read(4'd3, 0);
      checks++;
      if (host_if.rsp_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL deadbeef: rdata=%h, need deadbeef", host_if.rsp_rdata);
      end
   endtask

   task automatic test_partial_mask();
      do_write(4'd5, 4'hF, 32'h11223344);
      do_write(4'd5, 4'b0101, 32'hAABBCCDD);
      do_read(4'd5, 0);
      checks++;
      if (host_if.rsp_rdata !== 32'h11BB33DD) begin
         errors++;
         $display("FAIL partial_mask: rdata=%h, need 11bb33dd", host_if.rsp_rdata);
      end
   endtask

   task automatic test_zero_mask();
      do_write(4'd5, 4'h0, 32'hFFFFFFFF);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (sram_csb0 !== 1'b1 || host_if.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_mask_idle: csb=%b ready=%b, need 1 1", sram_csb0, host_if.req_ready);
         end
      end
      do_read(4'd5, 0);
   endtask

   task automatic test_backpressure();
      do_write(4'd9, 4'hF, 32'hCAFEF00D);
      do_read(4'd9, 10);
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      host_if.req_valid = 1'b1;
      host_if.req_we    = 1'b1;
      host_if.req_wmask = 4'hF;
      for (int i = 0; i < 4; i++) begin
         a = AW'(i + 10);
         d = $urandom;
         host_if.req_addr  = a;
         host_if.req_wdata = d;
         step();
         ref_mem[a] = d;
         checks++;
         if ({sram_csb0, sram_web0, sram_addr0, sram_din0, host_if.req_ready} !== {1'b0, 1'b0, a, d, 1'b1}) begin
            errors++;
            $display("FAIL b2b_write %0d: csb=%b web=%b addr=%h din=%h ready=%b, need 0 0 %h %h 1",
                     i, sram_csb0, sram_web0, sram_addr0, sram_din0, host_if.req_ready, a, d);
         end
      end
      host_if.req_valid = 1'b0;
      do_read(4'd13, 0);
      do_read(4'd10, 1);
   endtask

   task automatic test_reset_during_read();
      do_write(4'd7, 4'hF, 32'h0BADCAFE);
      wait_ready("rst_read");
      host_if.req_valid = 1'b1;
      host_if.req_we    = 1'b0;
      host_if.req_addr  = 4'd7;
      host_if.rsp_ready = 1'b1;
      step();
      host_if.req_valid = 1'b0;
      step();
      rst0 = 1'b1;
      #1;
      checks++;
      if (sram_csb0 !== 1'b1 || host_if.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_read: csb=%b rsp_valid=%b, need 1 0", sram_csb0, host_if.rsp_valid);
      end
      step();
      rst0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (host_if.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_rsp cycle %0d: rsp_valid=%b, need 0", i, host_if.rsp_valid);
         end
      end
`ifdef SRAM_CTRL_CLEAR_EN
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
`endif
      host_if.rsp_ready = 1'b0;
      wait_ready("after_reset");
      do_read(4'd7, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < int'(DEPTH); i++) do_write(AW'(i), 4'hF, $urandom);
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(1, 0) == 1)
            do_write(AW'($urandom_range(DEPTH - 1, 0)), MW'($urandom), $urandom);
         else
            do_read(AW'($urandom_range(DEPTH - 1, 0)), int'($urandom_range(3, 0)));
      end
   endtask

   initial begin
      host_if.req_valid = 1'b0;
      host_if.req_we    = 1'b0;
      host_if.req_addr  = '0;
      host_if.req_wmask = '0;
      host_if.req_wdata = '0;
      host_if.rsp_ready = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 'x;
      apply_reset();
      test_reset();
`ifdef SRAM_CTRL_CLEAR_EN
      test_init();
`endif
      test_write_read();
      test_partial_mask();
      test_zero_mask();
      test_backpressure();
      test_back_to_back();
      test_reset_during_read();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end
endmodule
